// File: rtl/uart_rx_if.sv
// Receive-side byte handshake between uart_rx and its consumer.
// The receiver drives data, status and pulses; the consumer drives rx_ready.
interface uart_rx_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    modport master (
        output rx_data, rx_valid, frame_err, overrun, busy,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, frame_err, overrun, busy,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, centre sampling, single-entry
// holding register with valid/ready handshake, framing and overrun pulses.
module uart_rx #(
    parameter int unsigned F_CLK = 48_000_000,
    parameter int unsigned BAUD  = 115_200
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      rxd,
    uart_rx_if.master rx_bus
);
    localparam int unsigned CLKS_PER_BIT = F_CLK / BAUD;
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    state_t           state, state_n;
    logic [1:0]       rx_sync;
    logic             rxs;
    logic [CNT_W-1:0] clk_cnt, clk_cnt_n;
    logic [2:0]       bit_idx, bit_idx_n;
    logic [7:0]       shift, shift_n;
    logic             done, ferr;
    logic [7:0]       data_q;
    logic             valid_q, frame_err_q, overrun_q;

    assign rxs = rx_sync[1];

    always_comb begin
        state_n   = state;
        clk_cnt_n = clk_cnt + 1'b1;
        bit_idx_n = bit_idx;
        shift_n   = shift;
        done      = 1'b0;
        ferr      = 1'b0;
        case (state)
            IDLE: begin
                clk_cnt_n = '0;
                if (!rxs) state_n = START;
            end
            START: begin
                if (clk_cnt == HALF_LAST) begin
                    clk_cnt_n = '0;
                    bit_idx_n = '0;
                    state_n   = rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                if (clk_cnt == BIT_LAST) begin
                    clk_cnt_n        = '0;
                    shift_n[bit_idx] = rxs;
                    bit_idx_n        = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_n = STOP;
                end
            end
            STOP: begin
                if (clk_cnt == BIT_LAST) begin
                    clk_cnt_n = '0;
                    if (rxs) begin
                        done    = 1'b1;
                        state_n = IDLE;
                    end else begin
                        ferr    = 1'b1;
                        state_n = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                // Hold off re-arming until the line recovers, so a break is one error.
                clk_cnt_n = '0;
                if (rxs) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sync <= '1;
            state   <= IDLE;
            clk_cnt <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            rx_sync <= {rx_sync[0], rxd};
            state   <= state_n;
            clk_cnt <= clk_cnt_n;
            bit_idx <= bit_idx_n;
            shift   <= shift_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= ferr;
            overrun_q   <= done && valid_q && !rx_bus.rx_ready;
            // A byte completing while the old one is being accepted replaces it without a gap.
            if (done && (!valid_q || rx_bus.rx_ready)) begin
                data_q  <= shift;
                valid_q <= 1'b1;
            end else if (valid_q && rx_bus.rx_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign rx_bus.rx_data   = data_q;
    assign rx_bus.rx_valid  = valid_q;
    assign rx_bus.frame_err = frame_err_q;
    assign rx_bus.overrun   = overrun_q;
    assign rx_bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: fast-baud instance for feature scenarios,
// default-baud instance for nominal and +3% skewed line rates.
`timescale 1ns/1ps
module tb_uart_rx;
    localparam int CPB      = 16;
    localparam int CPB_DEF  = 416;
    localparam int CPB_SKEW = 404;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic rxd   = 1'b1;
    logic rxd2  = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;
    int valid_cycles = 0, ferr_cnt = 0, ovr_cnt = 0;
    int valid2_cycles = 0, ferr2_cnt = 0, ovr2_cnt = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_q2[$];
    logic [7:0] e1, e2;

    always #5 clk = ~clk;

    uart_rx_if bus ();
    uart_rx_if bus2 ();

    uart_rx #(.F_CLK(48_000_000), .BAUD(3_000_000)) u_dut (
        .clk(clk), .rst_n(rst_n), .rxd(rxd), .rx_bus(bus)
    );

    uart_rx #(.F_CLK(48_000_000), .BAUD(115_200)) u_dut_def (
        .clk(clk), .rst_n(rst_n), .rxd(rxd2), .rx_bus(bus2)
    );

    // Scoreboard: every accepted byte must match the oldest expected one.
    always @(negedge clk) begin
        if (bus.rx_valid === 1'b1) valid_cycles++;
        if (bus.frame_err === 1'b1) ferr_cnt++;
        if (bus.overrun === 1'b1) ovr_cnt++;
        if (bus.rx_valid === 1'b1 && bus.rx_ready === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL accept_unexpected: got 0x%02h, required no byte", bus.rx_data);
            end else begin
                e1 = exp_q.pop_front();
                if (bus.rx_data !== e1) begin
                    n_fail++;
                    $display("FAIL accept_data: got 0x%02h, required 0x%02h", bus.rx_data, e1);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (bus2.rx_valid === 1'b1) valid2_cycles++;
        if (bus2.frame_err === 1'b1) ferr2_cnt++;
        if (bus2.overrun === 1'b1) ovr2_cnt++;
        if (bus2.rx_valid === 1'b1 && bus2.rx_ready === 1'b1) begin
            n_checks++;
            if (exp_q2.size() == 0) begin
                n_fail++;
                $display("FAIL def_accept_unexpected: got 0x%02h, required no byte", bus2.rx_data);
            end else begin
                e2 = exp_q2.pop_front();
                if (bus2.rx_data !== e2) begin
                    n_fail++;
                    $display("FAIL def_accept_data: got 0x%02h, required 0x%02h", bus2.rx_data, e2);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    task automatic drive_line(input int line, input logic v);
        if (line == 0) rxd = v;
        else rxd2 = v;
    endtask

    // Start bit falls 1 time unit after the first posedge seen by this task.
    task automatic send_frame(input int line, input logic [7:0] d, input logic stop_bit, input int bit_clks);
        logic [9:0] f;
        f = {stop_bit, d, 1'b0};
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            drive_line(line, f[i]);
            repeat (bit_clks) @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus.rx_data, bus.rx_valid, bus.frame_err, bus.overrun, bus.busy} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_outputs: got data=%h v=%b fe=%b ov=%b busy=%b, required all 0",
                     bus.rx_data, bus.rx_valid, bus.frame_err, bus.overrun, bus.busy);
        end
        n_checks++;
        if ({bus2.rx_valid, bus2.busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_def: got v=%b busy=%b, required 0 0", bus2.rx_valid, bus2.busy);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic test_single_byte();
        int lat, v0;
        bus.rx_ready = 1'b1;
        v0 = valid_cycles;
        exp_q.push_back(8'hA5);
        lat = -1;
        fork
            send_frame(0, 8'hA5, 1'b1, CPB);
            begin
                for (int i = 0; i < 200; i++) begin
                    @(posedge clk); #1;
                    if (bus.rx_valid && lat < 0) lat = i;
                end
            end
        join
        n_checks++;
        if (lat != 155) begin
            n_fail++;
            $display("FAIL single_latency: got %0d clk, required 155 clk", lat);
        end
        n_checks++;
        if (valid_cycles - v0 != 1) begin
            n_fail++;
            $display("FAIL single_valid_width: got %0d cycles, required 1", valid_cycles - v0);
        end
        n_checks++;
        if ({bus.frame_err, bus.overrun, bus.busy} !== 3'b000 || ferr_cnt != 0 || ovr_cnt != 0) begin
            n_fail++;
            $display("FAIL single_status: got fe_cnt=%0d ov_cnt=%0d busy=%b, required 0 0 0",
                     ferr_cnt, ovr_cnt, bus.busy);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL single_drained: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        int o0;
        bus.rx_ready = 1'b0;
        o0 = ovr_cnt;
        exp_q.push_back(8'h3C);
        send_frame(0, 8'h3C, 1'b1, CPB);
        send_frame(0, 8'hC3, 1'b1, CPB);
        repeat (4) @(posedge clk);
        #1;
        n_checks++;
        if (ovr_cnt - o0 != 1) begin
            n_fail++;
            $display("FAIL bp_overrun_count: got %0d pulses, required 1", ovr_cnt - o0);
        end
        n_checks++;
        if (bus.rx_valid !== 1'b1 || bus.rx_data !== 8'h3C) begin
            n_fail++;
            $display("FAIL bp_held: got v=%b data=0x%02h, required v=1 data=0x3c", bus.rx_valid, bus.rx_data);
        end
        bus.rx_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (bus.rx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_valid_fall: got %b, required 0", bus.rx_valid);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL bp_drained: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_simultaneous_accept();
        int o0;
        bus.rx_ready = 1'b0;
        exp_q.push_back(8'h11);
        send_frame(0, 8'h11, 1'b1, CPB);
        o0 = ovr_cnt;
        exp_q.push_back(8'h22);
        fork
            send_frame(0, 8'h22, 1'b1, CPB);
            begin
                repeat (155) @(posedge clk);
                #1 bus.rx_ready = 1'b1;
                @(posedge clk); #1 bus.rx_ready = 1'b0;
                n_checks++;
                if (bus.rx_valid !== 1'b1 || bus.rx_data !== 8'h22) begin
                    n_fail++;
                    $display("FAIL simul_reload: got v=%b data=0x%02h, required v=1 data=0x22",
                             bus.rx_valid, bus.rx_data);
                end
            end
        join
        n_checks++;
        if (ovr_cnt != o0) begin
            n_fail++;
            $display("FAIL simul_overrun: got %0d pulses, required 0", ovr_cnt - o0);
        end
        bus.rx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0 || bus.rx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_drained: got %0d pending v=%b, required 0 pending v=0", exp_q.size(), bus.rx_valid);
        end
    endtask

    task automatic test_glitch();
        int v0, f0;
        v0 = valid_cycles;
        f0 = ferr_cnt;
        @(posedge clk); #1 rxd = 1'b0;
        repeat (4) @(posedge clk);
        #1 rxd = 1'b1;
        n_checks++;
        if (bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL glitch_busy_rise: got %b, required 1", bus.busy);
        end
        repeat (20) @(posedge clk);
        #1;
        n_checks++;
        if (bus.busy !== 1'b0 || valid_cycles != v0 || ferr_cnt != f0) begin
            n_fail++;
            $display("FAIL glitch_reject: got busy=%b valid=%0d fe=%0d, required 0 0 0",
                     bus.busy, valid_cycles - v0, ferr_cnt - f0);
        end
    endtask

    task automatic test_framing();
        int v0, f0;
        v0 = valid_cycles;
        f0 = ferr_cnt;
        send_frame(0, 8'h55, 1'b0, CPB);
        repeat (100) @(posedge clk);
        #1;
        n_checks++;
        if (ferr_cnt - f0 != 1 || valid_cycles != v0) begin
            n_fail++;
            $display("FAIL frame_err_pulse: got fe=%0d valid=%0d, required fe=1 valid=0",
                     ferr_cnt - f0, valid_cycles - v0);
        end
        n_checks++;
        if (bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL frame_busy_low_line: got %b, required 1", bus.busy);
        end
        rxd = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if (bus.busy !== 1'b0 || ferr_cnt - f0 != 1) begin
            n_fail++;
            $display("FAIL frame_recover: got busy=%b fe=%0d, required busy=0 fe=1", bus.busy, ferr_cnt - f0);
        end
    endtask

    task automatic test_reset_midframe();
        int v0;
        bus.rx_ready = 1'b1;
        v0 = valid_cycles;
        @(posedge clk); #1 rxd = 1'b0;
        repeat (5 * CPB) @(posedge clk);
        #1 rxd = 1'b1;
        repeat (8) @(posedge clk);
        n_checks++;
        if (bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_busy_before: got %b, required 1", bus.busy);
        end
        #1 rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus.rx_data, bus.rx_valid, bus.frame_err, bus.overrun, bus.busy} !== 12'h000) begin
            n_fail++;
            $display("FAIL midreset_outputs: got data=%h v=%b fe=%b ov=%b busy=%b, required all 0",
                     bus.rx_data, bus.rx_valid, bus.frame_err, bus.overrun, bus.busy);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        exp_q.push_back(8'h0F);
        send_frame(0, 8'h0F, 1'b1, CPB);
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if (valid_cycles - v0 != 1 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL midreset_only_new: got valid=%0d pending=%0d, required valid=1 pending=0",
                     valid_cycles - v0, exp_q.size());
        end
    endtask

    task automatic test_default_baud(input int bit_clks, input int expect_total);
        exp_q2.push_back(8'h00);
        exp_q2.push_back(8'hFF);
        send_frame(1, 8'h00, 1'b1, bit_clks);
        send_frame(1, 8'hFF, 1'b1, bit_clks);
        repeat (20) @(posedge clk);
        #1;
        n_checks++;
        if (valid2_cycles != expect_total || exp_q2.size() != 0) begin
            n_fail++;
            $display("FAIL def_bytes_%0d: got valid=%0d pending=%0d, required valid=%0d pending=0",
                     bit_clks, valid2_cycles, exp_q2.size(), expect_total);
        end
        n_checks++;
        if (ferr2_cnt != 0 || ovr2_cnt != 0 || bus2.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL def_status_%0d: got fe=%0d ov=%0d busy=%b, required 0 0 0",
                     bit_clks, ferr2_cnt, ovr2_cnt, bus2.busy);
        end
    endtask

    initial begin
        bus.rx_ready  = 1'b0;
        bus2.rx_ready = 1'b1;
        test_reset();
        test_single_byte();
        test_backpressure();
        test_simultaneous_accept();
        test_glitch();
        test_framing();
        test_reset_midframe();
        test_default_baud(CPB_DEF, 2);
        test_default_baud(CPB_SKEW, 4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver for the FTDI serial_rxd line on the UPduino. Runs on the 48 MHz SB_HFOSC clock.
- Synchronises the asynchronous line, validates the start bit, samples each bit at its centre, and presents bytes on a valid/ready interface.
- Pairs with the existing idle-high serial_txd path and feeds command/LED-control logic downstream.

Parameters:
- F_CLK, 48_000_000, system clock frequency in Hz.
- BAUD, 115_200, line rate in bit/s.
- Derived constants, not overridable:
  - CLKS_PER_BIT = F_CLK/BAUD, truncating integer divide. This is 416 at the defaults.
  - HALF_BIT = CLKS_PER_BIT/2, which is 208.
  - Counter width = $clog2(CLKS_PER_BIT).

Ports:
- clk  input  1  system clock, 48 MHz.
- rst_n  input  1  asynchronous active-low reset.
- rxd  input  1  raw serial line from the FTDI, idle high, asynchronous to clk.
- rx_data  output  8  received byte, LSB first on the wire. Stable while rx_valid=1.
- rx_valid  output  1  byte available. Held until accepted.
- rx_ready  input  1  consumer accepts rx_data in any cycle where rx_valid&&rx_ready.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: a completed byte was dropped because the holding register was full.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset, asynchronous on rst_n low:
  - Outputs: rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0.
  - Synchroniser flops preset to 1.
  - FSM=IDLE, bit counter=0, clock counter=0.
- Reset mid-frame aborts the frame with no output. After release, the block re-arms only on a fresh falling edge seen in IDLE.
- Synchroniser: two flops on rxd, called rxs. All decisions below use rxs only.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE:
  - On rxs=0: go to START, clock counter=0.
- START:
  - Count clocks. When the counter reaches HALF_BIT-1, sample rxs.
  - rxs=0: go to DATA, clock counter=0, bit index=0.
  - rxs=1: the start was a glitch. Return to IDLE with no pulse.
- DATA:
  - When the counter reaches CLKS_PER_BIT-1, sample rxs into shift[bit index] and reset the counter.
  - After bit index 7 is sampled, go to STOP.
- STOP:
  - When the counter reaches CLKS_PER_BIT-1, sample rxs.
  - rxs=1: the byte completes. Apply the holding-register rules below, then go to IDLE.
  - rxs=0: pulse frame_err for one cycle and discard the byte, leaving rx_data/rx_valid untouched. Go to WAIT_HIGH.
- WAIT_HIGH:
  - Remain until rxs=1, then go to IDLE. This prevents a break condition from producing repeated frames.
- Holding register (evaluated in the completion cycle; "next cycle" means the cycle after completion):
  - rx_valid=0: load rx_data. rx_valid=1 next cycle.
  - rx_valid=1 and rx_ready=1 in the same cycle: the old byte is consumed, the new byte is loaded, and rx_valid stays 1.
  - rx_valid=1 and rx_ready=0: the new byte is dropped and rx_data is kept. overrun pulses for one cycle.
- Handshake:
  - rx_valid falls the cycle after rx_valid&&rx_ready, unless a new byte completes in that same cycle.
  - rx_ready while rx_valid=0 has no effect.
- Latency:
  - Sampling point is mid stop bit. rx_valid rises the clock after that point.
  - Measured from the rxd falling edge to rx_valid: 2 sync cycles + HALF_BIT + 9*CLKS_PER_BIT + 1 clk, within ±1 clk depending on edge phase.
  - At the defaults this is about 3955 clk.
- Timing: the line is not resynchronised on data edges. Total baud error must stay below ±4%.
- busy=0 exactly when the FSM is in IDLE.

Test Plan:
- Bench uses F_CLK=48_000_000, BAUD=3_000_000 (CLKS_PER_BIT=16, HALF_BIT=8) unless noted.
- Single byte: drive 0xA5 as 8N1 with 16-clk bits, rx_ready=1 → rx_valid pulses for 1 cycle with rx_data=0xA5. frame_err=0, overrun=0, busy=0 afterwards.
- Back-pressure/overrun: send 0x3C then 0xC3 with rx_ready=0 → rx_data=0x3C, rx_valid held high. One overrun pulse occurs at the 0xC3 stop-bit sample. Raising rx_ready then yields 0x3C and rx_valid falls.
- Simultaneous accept: hold rx_ready low after 0x11, then assert rx_ready exactly in the completion cycle of 0x22 → no overrun. rx_valid stays 1 and rx_data=0x22 next cycle.
- Glitch and framing:
  - A 4-clk low pulse on rxd → no rx_valid, no frame_err, busy returns to 0.
  - Byte 0x55 with the stop bit driven low, then rxd held low for 100 clk → exactly one frame_err pulse and no rx_valid. busy stays 1 until rxd goes high.
- Reset mid-frame: assert rst_n low during bit 4 of 0xF0, release, then send 0x0F → all outputs are 0 during reset. Only 0x0F is received.
- Default baud: F_CLK=48 MHz, BAUD=115200, send 0x00 and 0xFF back-to-back with rx_ready=1 → both bytes are received in order with no errors. Repeat with the sender baud skewed by +3% → the same result.
